// File: rtl/xnor_pop_accum_threshold.sv
// rtl/xnor_pop_accum_threshold.sv - popcount accumulator with bipolar dot product and threshold activation
module xnor_pop_accum_threshold #(
    parameter int CHUNK_BITS = 576,
    parameter int CHUNKS     = 4,
    parameter int POP_W      = $clog2(CHUNK_BITS + 1),
    parameter int ACC_W      = $clog2(CHUNKS * CHUNK_BITS + 1),
    parameter int DOT_W      = ACC_W + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] pop_in,
    input  logic             abort,
    input  logic             thr_we,
    input  logic [DOT_W-1:0] thr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             act_out,
    output logic [DOT_W-1:0] dot_out,
    output logic             err
);

    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0]        LAST_CNT   = CNT_W'(CHUNKS - 1);
    localparam logic [POP_W-1:0]        MAX_POP    = POP_W'(CHUNK_BITS);
    localparam logic signed [DOT_W-1:0] FULL_SCALE = DOT_W'(CHUNKS * CHUNK_BITS);

    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        acc;
    logic signed [DOT_W-1:0] thr;

    logic                    last_beat;
    logic                    accept;
    logic                    over_range;
    logic [POP_W-1:0]        pop_v;
    logic [ACC_W-1:0]        total;
    logic signed [DOT_W-1:0] dot_calc;
    logic                    dot_ge;

    assign last_beat  = (cnt == LAST_CNT);
    // Only the closing beat waits on a pending result; a same-cycle consume frees the slot.
    assign in_ready   = !(last_beat && out_valid && !out_ready);
    assign accept     = in_valid && in_ready && !abort;
    assign over_range = (pop_in > MAX_POP);
    assign pop_v      = over_range ? MAX_POP : pop_in;
    assign total      = acc + ACC_W'(pop_v);
    // 2*total - CHUNKS*CHUNK_BITS: the shift is a zero-extended concatenation.
    assign dot_calc   = $signed({1'b0, total, 1'b0}) - FULL_SCALE;
    assign dot_ge     = (dot_calc >= thr);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            thr       <= '0;
            out_valid <= 1'b0;
            act_out   <= 1'b0;
            dot_out   <= '0;
            err       <= 1'b0;
        end else begin
            if (thr_we) begin
                thr <= $signed(thr_in);
            end
            if (accept && over_range) begin
                err <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (abort) begin
                cnt <= '0;
                acc <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    cnt       <= '0;
                    acc       <= '0;
                    dot_out   <= dot_calc;
                    act_out   <= dot_ge;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_xnor_pop_accum_threshold.sv
// tb/tb_xnor_pop_accum_threshold.sv - directed and random checks against a neuron-level reference model
module tb_xnor_pop_accum_threshold;

    localparam int CB     = 576;
    localparam int NCH    = 4;
    localparam int POP_W  = 10;
    localparam int DOT_W  = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [POP_W-1:0] pop_in;
    logic             abort;
    logic             thr_we;
    logic [DOT_W-1:0] thr_in;
    logic             out_valid;
    logic             out_ready;
    logic             act_out;
    logic [DOT_W-1:0] dot_out;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats collected toward the current neuron and the last published result.
    int m_beats, m_sum, m_thr, m_dot;
    bit m_valid, m_act, m_err;

    xnor_pop_accum_threshold dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pop_in(pop_in), .abort(abort), .thr_we(thr_we), .thr_in(thr_in),
        .out_valid(out_valid), .out_ready(out_ready), .act_out(act_out),
        .dot_out(dot_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dot_now();
        return int'($signed(dot_out));
    endfunction

    task automatic model_reset();
        m_beats = 0; m_sum = 0; m_thr = 0; m_dot = 0;
        m_valid = 0; m_act = 0; m_err = 0;
    endtask

    // One clock: check in_ready against the model, advance the model, then check the outputs.
    task automatic cycle();
        bit exp_ready, take;
        int pv, old_thr;
        #1;
        exp_ready = !(m_beats == NCH - 1 && m_valid && !out_ready);
        chk("in_ready", int'(in_ready), int'(exp_ready));
        take = in_valid && exp_ready && !abort;
        pv = (int'(pop_in) > CB) ? CB : int'(pop_in);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            old_thr = m_thr;
            if (thr_we) m_thr = int'($signed(thr_in));
            if (take && int'(pop_in) > CB) m_err = 1;
            if (m_valid && out_ready) m_valid = 0;
            if (abort) begin
                m_beats = 0; m_sum = 0;
            end else if (take) begin
                m_sum += pv;
                m_beats++;
                if (m_beats == NCH) begin
                    m_dot = 2 * m_sum - NCH * CB;
                    m_act = (m_dot >= old_thr);
                    m_valid = 1;
                    m_beats = 0; m_sum = 0;
                end
            end
        end
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("dot_out", dot_now(), m_dot);
        chk("act_out", int'(act_out), int'(m_act));
        chk("err", int'(err), int'(m_err));
    endtask

    task automatic drive(input bit v, input int pop, input bit ab, input bit twe,
                         input int tin, input bit ordy);
        in_valid = v; pop_in = POP_W'(pop); abort = ab;
        thr_we = twe; thr_in = DOT_W'(tin); out_ready = ordy;
        cycle();
    endtask

    task automatic vec4(input int p, input bit ordy);
        for (int i = 0; i < 4; i++) drive(1, p, 0, 0, 0, ordy);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dot", dot_now(), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        vec4(576, 1);
        chk("full_dot", dot_now(), 2304);
        chk("full_act", int'(act_out), 1);
        drive(0, 0, 0, 0, 0, 1);

        vec4(288, 1);
        chk("eq_dot", dot_now(), 0);
        chk("eq_act", int'(act_out), 1);
        for (int i = 0; i < 3; i++) drive(1, 288, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1, 1);
        drive(1, 288, 0, 0, 0, 1);
        chk("thr1_act", int'(act_out), 0);
        drive(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 288, 0, 0, 0, 1);
        drive(1, 288, 0, 1, 1, 1);
        chk("thr_same_cycle_act", int'(act_out), 1);
        drive(0, 0, 0, 1, 0, 1);

        vec4(0, 0);
        chk("bp_a_dot", dot_now(), -2304);
        chk("bp_a_act", int'(act_out), 0);
        for (int i = 0; i < 3; i++) drive(1, 500, 0, 0, 0, 0);
        drive(1, 500, 0, 0, 0, 0);
        drive(1, 500, 0, 0, 0, 0);
        chk("bp_stall_ready", int'(in_ready), 0);
        chk("bp_a_stable", dot_now(), -2304);
        drive(1, 500, 0, 0, 0, 1);
        chk("bp_b_dot", dot_now(), 1696);
        chk("bp_b_valid", int'(out_valid), 1);
        drive(0, 0, 0, 0, 0, 1);

        drive(1, 576, 0, 0, 0, 1);
        drive(1, 576, 0, 0, 0, 1);
        drive(1, 576, 1, 0, 0, 1);
        chk("abort_no_out", int'(out_valid), 0);
        vec4(100, 1);
        chk("abort_dot", dot_now(), -1504);
        chk("abort_act", int'(act_out), 0);
        drive(0, 0, 0, 0, 0, 1);

        drive(1, 600, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1);
        chk("range_err", int'(err), 1);
        chk("range_dot", dot_now(), -1152);

        for (int i = 0; i < 400; i++) begin
            int p;
            p = ($urandom_range(0, 19) == 0) ? int'($urandom_range(577, 1023))
                                             : int'($urandom_range(0, 576));
            drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 4800)) - 2400,
                  $urandom_range(0, 9) < 7);
        end

        drive(1, 576, 0, 0, 0, 0);
        drive(1, 576, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_err", int'(err), 0);
        vec4(576, 1);
        chk("midrst_dot", dot_now(), 2304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xnor_pop_accum_threshold.md
Name: xnor_pop_accum_threshold

Overview:
- Downstream stage of the XNOR/popcount unit.
- Accumulates CHUNKS successive popcount results, one per input chunk, that together form one full neuron fan-in.
- Converts the accumulated total to a bipolar dot product, compares it against a programmable threshold (folded batch-norm), and emits a 1-bit binary activation plus the dot value.
- Uses valid/ready handshakes on both sides so it can sit between a streaming popcount datapath and an activation buffer.

Parameters:
- CHUNK_BITS, 576, bits per popcount chunk (pop_size of the upstream unit); the maximum legal pop_in value.
- CHUNKS, 4, popcount beats per neuron; must be >= 1.
- POP_W, $clog2(CHUNK_BITS+1), pop_in width; 10 at default.
- ACC_W, $clog2(CHUNKS*CHUNK_BITS+1), accumulator width; 12 at default.
- DOT_W, ACC_W+2, signed width of the dot product and the threshold.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pop_in is valid.
- in_ready  out  1  block accepts pop_in this cycle.
- pop_in  in  POP_W  popcount of one chunk.
- abort  in  1  discard the partially accumulated neuron.
- thr_we  in  1  threshold write enable.
- thr_in  in  DOT_W  signed threshold value.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- act_out  out  1  binary activation: 1 iff dot >= threshold.
- dot_out  out  DOT_W  signed bipolar dot product.
- err  out  1  sticky flag: an out-of-range pop_in was seen.

Behaviour:
- Reset: cnt=0, acc=0, thr=0, out_valid=0, act_out=0, dot_out=0, err=0; in_ready=1 during and after reset.
- A beat is accepted when in_valid && in_ready && !abort.
- Clamping: pop_v = min(pop_in, CHUNK_BITS). If pop_in > CHUNK_BITS, err is set and stays set until rst.
- Non-last beat (cnt < CHUNKS-1):
  - acc <= acc + pop_v; cnt <= cnt+1.
  - in_ready is 1 regardless of output state.
- Last beat (cnt == CHUNKS-1):
  - total = acc + pop_v.
  - dot = 2*total - CHUNKS*CHUNK_BITS, computed in DOT_W signed arithmetic; range is ±CHUNKS*CHUNK_BITS.
  - act = (dot >= thr), signed compare.
  - dot_out, act_out and out_valid=1 are registered; acc <= 0, cnt <= 0.
  - Latency: result visible the cycle after the last beat is accepted.
- CHUNKS == 1: every accepted beat is a last beat.
- in_ready = !(cnt == CHUNKS-1 && out_valid && !out_ready). Only the last beat is stalled by a pending result; a same-cycle out_ready releases it, giving back-to-back throughput of one neuron per CHUNKS cycles.
- Output handshake:
  - out_valid && out_ready with no new last beat: out_valid <= 0; dot_out/act_out hold their last values.
  - Consume and new last beat in the same cycle: new result loaded, out_valid stays 1.
  - While out_valid && !out_ready, dot_out/act_out are stable.
- abort:
  - acc <= 0, cnt <= 0; any simultaneous in_valid beat is dropped (in_ready still reflects the formula).
  - Does not touch out_valid, dot_out, act_out, thr or err.
- Threshold:
  - thr_we loads thr <= thr_in at any time.
  - A last beat in the same cycle as thr_we compares against the old thr; the new value applies from the next cycle.
- rst mid-vector or with a pending output: everything returns to reset values next cycle and the pending result is lost.
- No state other than cnt and acc persists between neurons.

Test Plan:
- Reset: assert rst 2 cycles -> out_valid=0, act_out=0, dot_out=0, err=0, in_ready=1.
- Full match, thr=0: pop_in 576,576,576,576 on consecutive cycles -> one cycle after beat 4, out_valid=1, dot_out=2304, act_out=1.
- Equality boundary: four beats of 288 with thr=0 -> dot_out=0, act_out=1. Repeat with thr_we=1, thr_in=1 written before beat 4 -> act_out=0. Write thr=1 in the same cycle as beat 4 -> compare uses 0, act_out=1.
- Backpressure: out_ready=0, vector A (all 0s) -> dot_out=-2304, act_out=0.
  - Vector B: beats 1-3 accepted; beat 4 sees in_ready=0 while out_ready=0, and A's result stays stable.
  - Raise out_ready -> beat 4 accepted that cycle, next cycle dot_out = B's value, out_valid stays 1.
- Abort: two beats of 576, then abort together with a third in_valid beat -> beat dropped, no output.
  - Then four beats of 100 -> dot_out=2*400-2304=-1504, act_out=0 (thr=0).
- Range error: one beat pop_in=600 followed by three beats of 0 -> err=1 (sticky), beat clamped to 576, dot_out=2*576-2304=-1152.
